// File: rtl/alu_exec_unit.sv
// Execute-stage unit sitting behind the ALU control decoder.
// Single-cycle ops finish one cycle after accept.
// Shifts move one bit per cycle. MUL is a 32-step shift-and-add.
// Valid/ready on both sides lets the core stall while a long op runs.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      AluCtrl,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Err
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_r, next_state_s, accept_target_s;
  logic [3:0]        op_r;
  logic [XLEN-1:0]   shval_r, acc_r, mcand_r, mplier_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   result_r;
  logic              zero_r, err_r, out_valid_r;

  logic [XLEN-1:0]   single_res_s, shift_step_s, acc_step_s;
  logic              single_err_s, is_shift_s, is_mul_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic              in_ready_s, accept_s;

  // Decode the incoming op and compute the single-cycle result.
  always_comb begin
    single_res_s = '0;
    single_err_s = 1'b0;
    is_shift_s   = 1'b0;
    is_mul_s     = 1'b0;
    shamt_s      = OpB[SHAMT_W-1:0];
    case (AluCtrl)
      OP_AND: single_res_s = OpA & OpB;
      OP_OR:  single_res_s = OpA | OpB;
      OP_ADD: single_res_s = OpA + OpB;
      OP_SUB: single_res_s = OpA - OpB;
      OP_SLT: single_res_s = {{(XLEN-1){1'b0}}, ($signed(OpA) < $signed(OpB))};
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift_s   = 1'b1;
        single_res_s = OpA;  // shamt=0 finishes on the single-cycle path
      end
      OP_MUL: is_mul_s = 1'b1;
      default: single_err_s = 1'b1;
    endcase
  end

  // One-bit shift step and one shift-and-add step for the iterative ops.
  always_comb begin
    shift_step_s = shval_r;
    case (op_r)
      OP_SLL:  shift_step_s = {shval_r[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, shval_r[XLEN-1:1]};
      OP_SRA:  shift_step_s = {shval_r[XLEN-1], shval_r[XLEN-1:1]};
      default: shift_step_s = shval_r;
    endcase
    if (mplier_r[0]) begin
      acc_step_s = acc_r + mcand_r;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Handshake and next-state selection.
  always_comb begin
    in_ready_s = rst_n && ((state_r == S_IDLE) || ((state_r == S_DONE) && out_ready));
    accept_s   = in_valid && in_ready_s;
    if (is_mul_s) begin
      accept_target_s = S_MUL;
    end else if (is_shift_s && (shamt_s != '0)) begin
      accept_target_s = S_SHIFT;
    end else begin
      accept_target_s = S_DONE;
    end
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) next_state_s = accept_target_s;
        else          next_state_s = S_IDLE;
      end
      S_SHIFT: begin
        if (cnt_r == CNT_ONE) next_state_s = S_DONE;
        else                  next_state_s = S_SHIFT;
      end
      S_MUL: begin
        if (cnt_r == MUL_LAST) next_state_s = S_DONE;
        else                   next_state_s = S_MUL;
      end
      S_DONE: begin
        if (accept_s)       next_state_s = accept_target_s;
        else if (out_ready) next_state_s = S_IDLE;
        else                next_state_s = S_DONE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= next_state_s;
  end

  // Datapath registers: iteration state and the registered result bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r        <= 4'b0000;
      shval_r     <= '0;
      acc_r       <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      cnt_r       <= '0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_SHIFT: begin
          shval_r <= shift_step_s;
          cnt_r   <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r    <= shift_step_s;
            zero_r      <= (shift_step_s == '0);
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        S_MUL: begin
          acc_r    <= acc_step_s;
          mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == MUL_LAST) begin
            result_r    <= acc_step_s;
            zero_r      <= (acc_step_s == '0);
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
      // A new request overrides whatever the current state did above.
      if (accept_s) begin
        op_r <= AluCtrl;
        if (is_mul_s) begin
          acc_r       <= '0;
          mcand_r     <= OpA;
          mplier_r    <= OpB;
          cnt_r       <= '0;
          out_valid_r <= 1'b0;
        end else if (is_shift_s && (shamt_s != '0)) begin
          shval_r     <= OpA;
          cnt_r       <= {1'b0, shamt_s};
          out_valid_r <= 1'b0;
        end else begin
          result_r    <= single_res_s;
          zero_r      <= (single_res_s == '0);
          err_r       <= single_err_s;
          out_valid_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Zero      = zero_r;
  assign Err       = err_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a behavioural reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  AluCtrl = 4'b0000;
  logic [31:0] OpA = 32'd0;
  logic [31:0] OpB = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;
  logic        Zero;
  logic        Err;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .AluCtrl(AluCtrl), .OpA(OpA), .OpB(OpB), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .Err(Err)
  );

  always #5 clk = ~clk;

  // Reference: {Err, Zero, Result} straight from the op definitions.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    logic [63:0] p;
    r = 32'd0;
    e = 1'b0;
    p = 64'(a) * 64'(b);
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1011: r = 32'($signed(a) >>> b[4:0]);
      4'b1010: r = p[31:0];
      default: e = 1'b1;
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  // Reference latency in cycles from the accept cycle to out_valid.
  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
    if (c == 4'b1010) return 33;
    if (c == 4'b1000 || c == 4'b1001 || c == 4'b1011) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op with out_ready low; return latency and the held outputs.
  task automatic drive_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit ready_leak, output logic [33:0] obs);
    int w;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    AluCtrl   = c;
    OpA       = a;
    OpB       = b;
    w = 0;
    ready_leak = 1'b0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    AluCtrl  = 4'($urandom);
    OpA      = $urandom;
    OpB      = $urandom;
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    obs = {Err, Zero, Result};
  endtask

  // Consume the pending result.
  task automatic pop;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, Result, Zero, Err} !== 35'd0)
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b e=%b, want all 0",
               in_ready, out_valid, Result, Zero, Err);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add;
    int lat; bit leak; logic [33:0] obs;
    drive_op(4'b0010, 32'h7FFF_FFFF, 32'd1, lat, leak, obs);
    total_cnt++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (obs !== {1'b0, 1'b0, 32'h8000_0000}) $display("FAIL add_result: got %h want %h", obs, {2'b00, 32'h8000_0000});
    else pass_cnt++;
    pop();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL add_pop: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  c [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    c[0] = 4'b0110; a[0] = 32'd5;         b[0] = 32'd5;
    c[1] = 4'b0111; a[1] = 32'hFFFF_FFFF; b[1] = 32'd1;
    c[2] = 4'b0000; a[2] = 32'h0000_F0F0; b[2] = 32'h0000_FF00;
    c[3] = 4'b0001; a[3] = 32'h0000_F0F0; b[3] = 32'h0000_FF00;
    for (int i = 4; i < 8; i++) begin
      case ($urandom_range(0, 4))
        0: c[i] = 4'b0000;
        1: c[i] = 4'b0001;
        2: c[i] = 4'b0010;
        3: c[i] = 4'b0110;
        default: c[i] = 4'b0111;
      endcase
      a[i] = $urandom;
      b[i] = $urandom;
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    AluCtrl = c[0]; OpA = a[0]; OpB = b[0];
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, Err, Zero, Result} !== {1'b1, model(c[i], a[i], b[i])})
        $display("FAIL b2b_result[%0d]: got vld=%b %h want vld=1 %h", i, out_valid,
                 {Err, Zero, Result}, model(c[i], a[i], b[i]));
      else pass_cnt++;
      if (i < 7) begin
        AluCtrl = c[i+1]; OpA = a[i+1]; OpB = b[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  // Shared by the shift, MUL and random scenarios: issue, compare, pop.
  task automatic run_checked(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int lat; bit leak; logic [33:0] obs;
    drive_op(c, a, b, lat, leak, obs);
    total_cnt++;
    if (lat !== exp_lat(c, b)) $display("FAIL %s_latency: op=%b got %0d want %0d", tag, c, lat, exp_lat(c, b));
    else pass_cnt++;
    total_cnt++;
    if (obs !== model(c, a, b)) $display("FAIL %s_result: op=%b a=%h b=%h got %h want %h", tag, c, a, b, obs, model(c, a, b));
    else pass_cnt++;
    if (exp_lat(c, b) > 1) begin
      total_cnt++;
      if (leak) $display("FAIL %s_busy_ready: in_ready got 1 want 0 while busy", tag);
      else pass_cnt++;
    end
    pop();
  endtask

  task automatic test_shift;
    run_checked("sra31", 4'b1011, 32'h8000_0000, 32'd31);
    run_checked("srl31", 4'b1001, 32'h8000_0000, 32'd31);
    run_checked("sll0",  4'b1000, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0: run_checked("shift_rnd", 4'b1000, $urandom, $urandom);
        1: run_checked("shift_rnd", 4'b1001, $urandom, $urandom);
        default: run_checked("shift_rnd", 4'b1011, $urandom, $urandom);
      endcase
    end
  endtask

  task automatic test_mul;
    run_checked("mul_ff", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_checked("mul_dec", 4'b1010, 32'd12345, 32'd6789);
    for (int i = 0; i < 3; i++) run_checked("mul_rnd", 4'b1010, $urandom, $urandom);
  endtask

  task automatic test_backpressure;
    int lat; bit leak; logic [33:0] obs; logic [33:0] held;
    bit bad;
    drive_op(4'b1010, 32'd7, 32'd9, lat, leak, obs);
    held = obs;
    total_cnt++;
    if (obs !== model(4'b1010, 32'd7, 32'd9)) $display("FAIL bp_mul_result: got %h want %h", obs, model(4'b1010, 32'd7, 32'd9));
    else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      AluCtrl = 4'b0010; OpA = $urandom; OpB = $urandom;
      @(negedge clk);
      if ({Err, Zero, Result} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad) $display("FAIL bp_hold: got vld=%b rdy=%b %h want vld=1 rdy=0 %h", out_valid, in_ready, {Err, Zero, Result}, held);
    else pass_cnt++;
    pop();
    drive_op(4'b0011, 32'hDEAD_BEEF, 32'h1, lat, leak, obs);
    total_cnt++;
    if (obs !== {1'b1, 1'b1, 32'd0} || lat !== 1) $display("FAIL illegal_op: got %h lat=%0d want %h lat=1", obs, lat, {2'b11, 32'd0});
    else pass_cnt++;
    pop();
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) run_checked("rnd", 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  task automatic test_reset_mid_mul;
    int stale;
    @(negedge clk);
    in_valid = 1'b1;
    AluCtrl = 4'b1010; OpA = 32'd3; OpB = 32'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, Result} !== 34'd0) $display("FAIL midrst_state: got vld=%b rdy=%b res=%h want 0", out_valid, in_ready, Result);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midrst_idle: in_ready got %b want 1", in_ready);
    else pass_cnt++;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total_cnt++;
    if (stale != 0) $display("FAIL midrst_stale: out_valid high for %0d cycles want 0", stale);
    else pass_cnt++;
    run_checked("post_rst_add", 4'b0010, 32'd100, 32'd23);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_mul();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage unit directly downstream of the ALU control decoder: consumes the 4-bit AluCtrl code plus two 32-bit operands and produces Result/Zero for the datapath.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) return with a registered 1-cycle latency.
- Shifts and MUL run iteratively: 1 bit per cycle for shifts, 32 cycles for MUL.
- Valid/ready handshakes on both sides let the core stall on multi-cycle ops.

Parameters:
XLEN, 32, operand/result width; SHAMT_W and the MUL iteration count derive from it (log2(XLEN), XLEN).

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
AluCtrl  input  4  op code from ALU control
OpA  input  XLEN  operand A (rs1)
OpB  input  XLEN  operand B (rs2/imm); OpB[4:0] is shamt for shifts
out_valid  output  1  Result/Zero/Err valid
out_ready  input  1  consumer takes result this cycle
Result  output  XLEN  operation result
Zero  output  1  Result == 0
Err  output  1  unsupported AluCtrl code

Behaviour:
- Reset: clk and rst_n are the only clock/reset. Reset is synchronous and active-low: sampled only on the clk rising edge while rst_n=0.
- Reset state: state=IDLE, out_valid=0, Result=0, Zero=0, Err=0, counters=0. in_ready=0 while rst_n=0.
- Reset mid-operation: an in-flight op is discarded and no out_valid is produced for it.
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B, wraps mod 2^32).
  - 0111 SLT: signed A<B gives 1, else 0.
  - 1000 SLL, 1001 SRL, 1011 SRA (arithmetic, sign-filling).
  - 1010 MUL: low 32 bits of A*B; identical for signed and unsigned.
  - Any other code: Result=0, Err=1, single-cycle path.
- Accept: a transfer occurs when in_valid & in_ready is high at a rising edge (edge E0). Inputs are captured at E0 only; later input changes are ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready), gated by rst_n. This allows back-to-back single-cycle ops at 1 per cycle.
- States:
  - IDLE: accept goes to DONE (single-cycle op, or shift with shamt=0), SHIFT, or MUL.
  - SHIFT:
    - At E0, load the value and set cnt=shamt.
    - Each later edge shifts 1 bit and decrements cnt.
    - When cnt reaches 1 and that shift is done, go to DONE.
    - Latency: out_valid rises shamt+1 cycles after the accept cycle (1 cycle for shamt=0; 32 cycles for shamt=31).
  - MUL:
    - At E0, load acc=0, mcand=A, mplier=B, cnt=0.
    - Each edge E1..E32: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++.
    - After E32, go to DONE.
    - Latency: 33 cycles.
  - DONE: out_valid=1, with Result/Zero/Err held stable until out_ready=1.
    - out_ready & in_valid: accept the new op in the same edge, with the same transitions as from IDLE.
    - out_ready & !in_valid: go to IDLE, out_valid=0.
- Outputs: Zero is registered together with Result and always equals (Result==0). Result holds its last value in IDLE.
- out_ready is ignored when out_valid=0.
- SUB of equal operands gives Zero=1. This path is used for beq.

Test Plan:
- Reset then ADD: rst_n=0 for 2 cycles, then ADD A=0x7FFFFFFF, B=1 → out_valid 1 cycle after accept, Result=0x80000000, Zero=0, Err=0; during reset in_ready=0, out_valid=0.
- SUB/SLT/AND/OR back-to-back with out_ready=1: SUB 5-5 → Result=0, Zero=1; SLT A=0xFFFFFFFF, B=1 → 1; AND 0xF0F0,0xFF00 → 0xF000; OR → 0xFFF0; one result per cycle, in_ready held 1.
- Shifts: SRA A=0x80000000 shamt=31 → 0xFFFFFFFF at 32 cycles; SRL same → 0x00000001; SLL shamt=0 → A unchanged, latency 1; in_ready=0 while in SHIFT.
- MUL: A=0xFFFFFFFF, B=0xFFFFFFFF → 0x00000001 at exactly 33 cycles; A=12345, B=6789 → 83810205; Zero=0.
- Backpressure plus illegal code: MUL done with out_ready=0 for 5 cycles → Result stable, out_valid=1, in_ready=0; AluCtrl=0011 → Result=0, Err=1, Zero=1.
- Reset mid-MUL: rst_n=0 at cycle 10 of MUL → next edge state IDLE, out_valid=0, no stale result after reset released; next ADD completes normally.
